// File: rtl/prog_runner_pkg.sv
// Shared types and constants for the program loader / run controller.
// Pure declarations: no logic, no latency, no flow control.
package prog_runner_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} runner_state_t;

  typedef enum logic [1:0] {HC_NONE, HC_HALT, HC_PC_OOR, HC_TIMEOUT} halt_cause_t;

  localparam logic [31:0] HALT_EBREAK = 32'h00100073;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// One-cycle update latency; holds at MAX instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != WIDTH'(MAX))) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/prog_runner.sv
// Loads a program into imem over valid/ready with the core held in reset, then runs it to a halt.
// Writes land one cycle after each handshake; ld_ready stays low outside LOAD and once imem is full.
module prog_runner
  import prog_runner_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              IMEM_SIZE  = 1024,
  parameter int              MAX_CYCLES = 10000,
  parameter logic [XLEN-1:0] HALT_INSTR = HALT_EBREAK,
  parameter int              CNT_W      = $clog2(MAX_CYCLES + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  ld_valid,
  output logic                                  ld_ready,
  input  logic [XLEN-1:0]                       ld_data,
  input  logic                                  ld_last,
  output logic                                  imem_wen,
  output logic [$clog2(IMEM_SIZE)-1:0]          imem_waddr,
  output logic [XLEN-1:0]                       imem_wdata,
  output logic                                  core_rst_n,
  output logic                                  core_en,
  input  logic [XLEN-1:0]                       pc,
  input  logic [XLEN-1:0]                       instr,
  output logic                                  busy,
  output logic                                  done,
  output logic [1:0]                            halt_cause,
  output logic [$clog2(IMEM_SIZE/4+1)-1:0]      n_words,
  output logic [CNT_W-1:0]                      cycle_count
);

  localparam int MAX_WORDS = IMEM_SIZE / 4;
  localparam int AW        = $clog2(IMEM_SIZE);
  localparam int NW        = $clog2(MAX_WORDS + 1);

  runner_state_t state, next_state;
  halt_cause_t   cause_q, cause_next;

  logic            hs;
  logic            clr_cnt;
  logic            hit_instr, hit_pc, hit_tmo, halt_hit;
  logic [XLEN-1:0] img_end;

  assign img_end   = XLEN'({n_words, 2'b00});
  assign hit_instr = (instr == HALT_INSTR);
  assign hit_pc    = (pc >= img_end);
  assign hit_tmo   = (cycle_count == CNT_W'(MAX_CYCLES));
  assign halt_hit  = hit_instr | hit_pc | hit_tmo;

  assign ld_ready   = (state == LOAD) && (n_words < NW'(MAX_WORDS));
  assign hs         = ld_valid && ld_ready;
  // The halting instruction itself must never commit.
  assign core_en    = (state == RUN) && !halt_hit;
  assign busy       = (state == LOAD) || (state == RUN);
  assign done       = (state == DONE);
  assign halt_cause = cause_q;

  always_comb begin
    next_state = state;
    clr_cnt    = 1'b0;
    cause_next = HC_TIMEOUT;
    if (hit_instr) begin
      cause_next = HC_HALT;
    end else if (hit_pc) begin
      cause_next = HC_PC_OOR;
    end
    case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state = LOAD;
          clr_cnt    = 1'b1;
        end
      end
      LOAD: begin
        if (hs && (ld_last || (n_words == NW'(MAX_WORDS - 1)))) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (halt_hit) begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      core_rst_n <= 1'b0;
      imem_wen   <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      cause_q    <= HC_NONE;
      n_words    <= '0;
    end else begin
      state <= next_state;
      // Core stays out of reset through DONE so its state can be inspected.
      core_rst_n <= (next_state == RUN) || (next_state == DONE);
      imem_wen   <= hs;
      if (hs) begin
        imem_waddr <= AW'({n_words, 2'b00});
        imem_wdata <= ld_data;
        n_words    <= n_words + 1'b1;
      end
      if (clr_cnt) begin
        n_words <= '0;
        cause_q <= HC_NONE;
      end
      if ((state == RUN) && halt_hit) begin
        cause_q <= cause_next;
      end
    end
  end

  sat_counter #(
    .WIDTH (CNT_W),
    .MAX   (MAX_CYCLES)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cnt),
    .inc   (core_en),
    .count (cycle_count)
  );

endmodule

// File: tb/tb_prog_runner.sv
// Self-checking bench: a tiny addi/jal core stands in for the RV32I core; results checked against an ISA-level model.
module tb_prog_runner;
  import prog_runner_pkg::*;

  localparam int MAXC = 50;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n, start, ld_valid, ld_ready, ld_last;
  logic [31:0] ld_data;
  logic        imem_wen;
  logic [9:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        core_rst_n, core_en, busy, done;
  logic [31:0] pc, instr;
  logic [1:0]  halt_cause;
  logic [8:0]  n_words;
  logic [5:0]  cycle_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  prog_runner #(.XLEN(32), .IMEM_SIZE(1024), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .imem_wen(imem_wen), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .core_rst_n(core_rst_n), .core_en(core_en), .pc(pc),
    .instr(instr), .busy(busy), .done(done), .halt_cause(halt_cause), .n_words(n_words),
    .cycle_count(cycle_count)
  );

  // ---------------- stand-in core and write-through instruction memory ----------------
  logic [31:0] tb_mem [256];
  logic [31:0] regs [32];
  logic [31:0] core_pc;
  logic        mem_clr = 1'b0;
  logic [9:0]  wr_q [$];
  logic [31:0] i_imm, j_imm;
  logic [31:0] prog [300];

  assign pc    = core_pc;
  assign instr = (imem_wen && ({22'b0, imem_waddr} == core_pc)) ? imem_wdata :
                 (core_pc < 32'd1024) ? tb_mem[core_pc[9:2]] : 32'h0;
  assign i_imm = {{20{instr[31]}}, instr[31:20]};
  assign j_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= 32'h0;
      wr_q.delete();
    end else if (imem_wen) begin
      tb_mem[imem_waddr[9:2]] <= imem_wdata;
      wr_q.push_back(imem_waddr);
    end
    if (!core_rst_n) begin
      core_pc <= 32'h0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (core_en) begin
      if (instr[6:0] == 7'b1101111) begin
        if (instr[11:7] != 5'd0) regs[instr[11:7]] <= core_pc + 32'd4;
        core_pc <= core_pc + j_imm;
      end else begin
        if (instr[6:0] == 7'b0010011 && instr[14:12] == 3'b000 && instr[11:7] != 5'd0)
          regs[instr[11:7]] <= regs[instr[19:15]] + i_imm;
        core_pc <= core_pc + 32'd4;
      end
    end
  end

  // ---------------- encoders and ISA-level reference ----------------
  function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
    logic [11:0] i12;
    logic [4:0]  d, s;
    i12 = 12'(imm); d = 5'(rd); s = 5'(rs1);
    return {i12, s, 3'b000, d, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_jal(input int rd, input int off);
    logic [20:0] o;
    logic [4:0]  d;
    o = 21'(off); d = 5'(rd);
    return {o[20], o[10:1], o[11], o[19:12], d, 7'b1101111};
  endfunction

  // Runs the program instruction by instruction until one of the stop rules fires.
  function automatic void model(input int n, output int cause, output int cnt,
                                output logic [31:0] r1, output logic [31:0] r2, output logic [31:0] r3);
    logic [31:0] r [32];
    logic [31:0] p, w, lim, imm;
    for (int i = 0; i < 32; i++) r[i] = 0;
    p = 0; cnt = 0; cause = 0; lim = 32'(n * 4);
    for (int step = 0; step < 2000; step++) begin
      w = (p < lim) ? prog[p[9:2]] : 32'h0;
      if (w == HALT_EBREAK) begin cause = 1; break; end
      if (p >= lim) begin cause = 2; break; end
      if (cnt == MAXC) begin cause = 3; break; end
      if (w[6:0] == 7'b1101111) begin
        imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
        if (w[11:7] != 0) r[w[11:7]] = p + 4;
        p = p + imm;
      end else begin
        imm = {{20{w[31]}}, w[31:20]};
        if (w[6:0] == 7'b0010011 && w[14:12] == 0 && w[11:7] != 0) r[w[11:7]] = r[w[19:15]] + imm;
        p = p + 4;
      end
      cnt++;
    end
    r1 = r[1]; r2 = r[2]; r3 = r[3];
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic load(input int n, input bit gaps, output int acc);
    int  tries;
    bit  rdy, v;
    acc = 0; tries = 0;
    while (acc < n && tries < 4 * n + 50) begin
      @(negedge clk);
      rdy = ld_ready;
      if (!rdy && acc > 0) break;
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      ld_valid = v; ld_data = prog[acc]; ld_last = (acc == n - 1);
      @(posedge clk);
      if (v && rdy) acc++;
      tries++;
    end
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic start_prog(input int n, input bit gaps, output int acc);
    @(negedge clk);
    mem_clr = 1'b1; start = 1'b1;
    @(negedge clk);
    mem_clr = 1'b0; start = 1'b0;
    load(n, gaps, acc);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; return; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    vectors++;
    if ({core_rst_n, core_en, ld_ready, imem_wen, done, busy} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 000000", {core_rst_n, core_en, ld_ready, imem_wen, done, busy});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({imem_waddr, imem_wdata, halt_cause, n_words, cycle_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_vals: waddr %0d wdata %h cause %0d nw %0d cnt %0d, expected all 0",
               imem_waddr, imem_wdata, halt_cause, n_words, cycle_count);
    end
    vectors++;
    if ({ld_ready, busy, core_rst_n} !== 3'b000) begin
      miscompares++;
      $display("FAIL idle_after_reset: rdy/busy/crst %b expected 000", {ld_ready, busy, core_rst_n});
    end
  endtask

  task automatic test_load_halt;
    int acc; bit ok;
    prog[0] = enc_addi(1, 0, 5); prog[1] = enc_addi(2, 1, 1); prog[2] = HALT_EBREAK;
    start_prog(3, 1'b1, acc);
    wait_done(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL halt_done: done never seen, expected within budget"); end
    vectors++;
    if (wr_q.size() != 3) begin miscompares++; $display("FAIL halt_writes: got %0d expected 3", wr_q.size()); end
    for (int k = 0; k < 3 && k < wr_q.size(); k++) begin
      vectors++;
      if (wr_q[k] !== 10'(k * 4)) begin miscompares++; $display("FAIL halt_waddr%0d: got %0d expected %0d", k, wr_q[k], k * 4); end
    end
    vectors++;
    if (halt_cause !== 2'd1 || cycle_count !== 6'd2) begin
      miscompares++; $display("FAIL halt_result: cause %0d cnt %0d expected 1 2", halt_cause, cycle_count);
    end
    vectors++;
    if (regs[2] !== 32'd6) begin miscompares++; $display("FAIL halt_x2: got %0d expected 6", regs[2]); end
  endtask

  task automatic test_pc_oor;
    int acc; bit ok;
    prog[0] = enc_addi(1, 0, 3); prog[1] = enc_addi(3, 1, 4);
    start_prog(2, 1'b0, acc);
    wait_done(ok);
    vectors++;
    if (!ok || halt_cause !== 2'd2 || cycle_count !== 6'd2 || pc !== 32'd8) begin
      miscompares++;
      $display("FAIL pc_oor: done %0d cause %0d cnt %0d pc %0d expected 1 2 2 8", ok, halt_cause, cycle_count, pc);
    end
  endtask

  task automatic test_timeout;
    int acc; bit ok;
    prog[0] = enc_jal(0, 0);
    start_prog(1, 1'b0, acc);
    wait_done(ok);
    vectors++;
    if (!ok || halt_cause !== 2'd3 || cycle_count !== 6'(MAXC)) begin
      miscompares++; $display("FAIL timeout: done %0d cause %0d cnt %0d expected 1 3 %0d", ok, halt_cause, cycle_count, MAXC);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if ({core_en, core_rst_n, done} !== 3'b011) begin
      miscompares++; $display("FAIL timeout_hold: en/crst/done %b expected 011", {core_en, core_rst_n, done});
    end
  endtask

  task automatic test_overflow;
    int acc; bit ok;
    for (int i = 0; i < 300; i++) prog[i] = NOP;
    start_prog(300, 1'b0, acc);
    ld_valid = 1'b1; ld_data = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    ld_valid = 1'b0;
    vectors++;
    if (acc != 256 || n_words !== 9'd256) begin
      miscompares++; $display("FAIL ovf_count: accepted %0d nw %0d expected 256 256", acc, n_words);
    end
    vectors++;
    if (wr_q.size() != 256 || ld_ready !== 1'b0 || core_rst_n !== 1'b1) begin
      miscompares++; $display("FAIL ovf_state: writes %0d rdy %0d crst %0d expected 256 0 1", wr_q.size(), ld_ready, core_rst_n);
    end
    wait_done(ok);
    vectors++;
    if (!ok || halt_cause !== 2'd3) begin
      miscompares++; $display("FAIL ovf_run: done %0d cause %0d expected 1 3", ok, halt_cause);
    end
  endtask

  task automatic test_start_in_run;
    int acc; bit ok;
    prog[0] = enc_jal(0, 0);
    start_prog(1, 1'b0, acc);
    repeat (8) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (core_rst_n !== 1'b1 || n_words !== 9'd1 || busy !== 1'b1 || ld_ready !== 1'b0) begin
      miscompares++; $display("FAIL start_in_run: crst %0d nw %0d busy %0d rdy %0d expected 1 1 1 0", core_rst_n, n_words, busy, ld_ready);
    end
    wait_done(ok);
    vectors++;
    if (!ok || halt_cause !== 2'd3 || cycle_count !== 6'(MAXC)) begin
      miscompares++; $display("FAIL start_in_run_end: done %0d cause %0d cnt %0d expected 1 3 %0d", ok, halt_cause, cycle_count, MAXC);
    end
  endtask

  task automatic test_reload_from_done;
    int acc; bit ok;
    // Entered in DONE with halt_cause 3 from the previous test.
    prog[0] = enc_addi(3, 0, 7); prog[1] = HALT_EBREAK;
    @(negedge clk);
    mem_clr = 1'b1; start = 1'b1;
    @(negedge clk);
    mem_clr = 1'b0; start = 1'b0;
    vectors++;
    if (n_words !== 0 || cycle_count !== 0 || halt_cause !== 0 || core_rst_n !== 1'b0 || ld_ready !== 1'b1) begin
      miscompares++; $display("FAIL reload_clear: nw %0d cnt %0d cause %0d crst %0d rdy %0d expected 0 0 0 0 1",
                              n_words, cycle_count, halt_cause, core_rst_n, ld_ready);
    end
    load(2, 1'b0, acc);
    wait_done(ok);
    vectors++;
    if (!ok || halt_cause !== 2'd1 || cycle_count !== 6'd1 || regs[3] !== 32'd7) begin
      miscompares++; $display("FAIL reload_run: done %0d cause %0d cnt %0d x3 %0d expected 1 1 1 7", ok, halt_cause, cycle_count, regs[3]);
    end
  endtask

  task automatic test_reset_mid_run;
    int acc;
    prog[0] = enc_addi(1, 0, 1); prog[1] = enc_jal(0, -4);
    start_prog(2, 1'b0, acc);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({core_rst_n, core_en, ld_ready, imem_wen, done, busy} !== 6'b0) begin
      miscompares++; $display("FAIL midrun_ctrl: got %b expected 000000", {core_rst_n, core_en, ld_ready, imem_wen, done, busy});
    end
    vectors++;
    if ({imem_waddr, imem_wdata, halt_cause, n_words, cycle_count} !== '0) begin
      miscompares++; $display("FAIL midrun_vals: waddr %0d wdata %h cause %0d nw %0d cnt %0d expected all 0",
                              imem_waddr, imem_wdata, halt_cause, n_words, cycle_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, core_rst_n} !== 3'b000) begin
      miscompares++; $display("FAIL midrun_idle: busy/done/crst %b expected 000", {busy, done, core_rst_n});
    end
  endtask

  task automatic test_random;
    int acc, n, r, tgt, e_cause, e_cnt;
    bit ok;
    logic [31:0] e1, e2, e3;
    for (int t = 0; t < 20; t++) begin
      n = $urandom_range(2, 20);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 9);
        if (r < 6) begin
          prog[i] = enc_addi($urandom_range(1, 3), $urandom_range(0, 3), $urandom_range(0, 127) - 64);
        end else if (r < 8) begin
          tgt = $urandom_range(0, n);
          prog[i] = enc_jal($urandom_range(0, 3), (tgt - i) * 4);
        end else begin
          prog[i] = HALT_EBREAK;
        end
      end
      model(n, e_cause, e_cnt, e1, e2, e3);
      start_prog(n, t[0], acc);
      wait_done(ok);
      vectors++;
      if (!ok || halt_cause !== 2'(e_cause) || cycle_count !== 6'(e_cnt)) begin
        miscompares++; $display("FAIL rand%0d_result: done %0d cause %0d cnt %0d expected 1 %0d %0d", t, ok, halt_cause, cycle_count, e_cause, e_cnt);
      end
      vectors++;
      if (n_words !== 9'(n) || wr_q.size() != n) begin
        miscompares++; $display("FAIL rand%0d_load: nw %0d writes %0d expected %0d", t, n_words, wr_q.size(), n);
      end
      vectors++;
      if (regs[1] !== e1 || regs[2] !== e2 || regs[3] !== e3) begin
        miscompares++; $display("FAIL rand%0d_regs: x1 %h x2 %h x3 %h expected %h %h %h", t, regs[1], regs[2], regs[3], e1, e2, e3);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 32'h0;
    test_reset();
    test_load_halt();
    test_pc_oor();
    test_timeout();
    test_overflow();
    test_start_in_run();
    test_reload_from_done();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
